// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial ALU.
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int CNT_W = $clog2(ALU_W);

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Full-adder carry: majority of the three inputs
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/mux4.sv
// One-bit 4:1 selector.
module mux4 (
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic [1:0] s,
  output logic       y
);

  // Pick one of four data bits by s
  always_comb begin
    y = d0;
    case (s)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial 8-bit ALU (AND/OR/XOR/ADD), one operand bit per clock, LSB first.
// Optional feature: define SERIAL_ALU_OVF_EN to add the signed-overflow output ovf.
module serial_alu_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  // Holds bits 0..6; the final bit goes straight into result, so an eighth
  // stage would only ever hold a bit that is shifted out unused.
  logic [ALU_W-2:0] sh;
  logic [ALU_W-1:0] a_q;
  logic [ALU_W-1:0] b_q;
  alu_op_t          op_q;

  logic             a_bit;
  logic             b_bit;
  logic             d0, d1, d2, d3;
  logic             sel_bit;
  logic             cy_next;
  logic [ALU_W-1:0] res_next;
  logic             accept;
  logic             last_bit;

  // Per-bit candidates, next carry and the word as it stands after this bit
  always_comb begin
    a_bit    = a_q[cnt];
    b_bit    = b_q[cnt];
    d0       = a_bit & b_bit;
    d1       = a_bit | b_bit;
    d2       = a_bit ^ b_bit;
    d3       = a_bit ^ b_bit ^ cy;
    cy_next  = (op_q == OP_ADD) ? maj3(a_bit, b_bit, cy) : 1'b0;
    res_next = {sel_bit, sh};
    accept   = start && (state != ST_RUN);
    last_bit = (cnt == CNT_W'(ALU_W - 1));
  end

  mux4 u_sel (
    .d0 (d0),
    .d1 (d1),
    .d2 (d2),
    .d3 (d3),
    .s  (op_q),
    .y  (sel_bit)
  );

  // Sequencer: capture on accept, shift one bit per RUN cycle, publish at DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cy     <= 1'b0;
      sh     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          sh  <= res_next[ALU_W-1:1];
          cy  <= cy_next;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= res_next;
            carry  <= cy_next;
            zero   <= (res_next == '0);
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= (op_q == OP_ADD) && (a_q[ALU_W-1] == b_q[ALU_W-1]) &&
                      (res_next[ALU_W-1] != a_q[ALU_W-1]);
`endif
          end
        end
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            a_q   <= a;
            b_q   <= b;
            op_q  <= alu_op_t'(op);
            cnt   <= '0;
            cy    <= 1'b0;
            sh    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq; define SERIAL_ALU_OVF_EN to also cover ovf.
module tb_serial_alu_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a     = '0;
  logic [7:0] b     = '0;
  logic [1:0] op    = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       ovf_s;

  serial_alu_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .result (result),
    .carry  (carry),
`ifdef SERIAL_ALU_OVF_EN
    .zero   (zero),
    .ovf    (ovf_s)
`else
    .zero   (zero)
`endif
  );

`ifndef SERIAL_ALU_OVF_EN
  assign ovf_s = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    int         due;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Values the outputs must hold between completions
  logic [7:0] h_res = 8'h00;
  logic       h_c   = 1'b0;
  logic       h_z   = 1'b1;
  logic       h_v   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Reference behaviour from whole-word arithmetic
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic [1:0] o, input int due);
    exp_t       e;
    logic [8:0] s;
    s     = {1'b0, x} + {1'b0, y};
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.due = due;
    case (o)
      2'b00:   e.res = x & y;
      2'b01:   e.res = x | y;
      2'b10:   e.res = x ^ y;
      default: begin
        e.res = s[7:0];
        e.c   = s[8];
        e.v   = (x[7] == y[7]) && (e.res[7] != x[7]);
      end
    endcase
    e.z = (e.res == 8'h00);
    return e;
  endfunction

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o,
                      input bit keep);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("send_wait_busy");
    a     = x;
    b     = y;
    op    = o;
    start = 1'b1;
    q.push_back(model(x, y, o, cyc + 9));
    @(negedge clk);
    if (!keep) start = 1'b0;
    else begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 2'($urandom);
    end
  endtask

  // Monitor: pops the scoreboard on done, otherwise checks busy and held outputs
  initial begin
    exp_t e;
    bit   exp_busy;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (done) begin
          if (q.size() == 0) fail_now("spurious_done");
          else begin
            e = q.pop_front();
            chk("latency", 32'(cyc), 32'(e.due));
            chk("result", 32'(result), 32'(e.res));
            chk("carry", 32'(carry), 32'(e.c));
            chk("zero", 32'(zero), 32'(e.z));
`ifdef SERIAL_ALU_OVF_EN
            chk("ovf", 32'(ovf_s), 32'(e.v));
`endif
            h_res = e.res;
            h_c   = e.c;
            h_z   = e.z;
            h_v   = e.v;
          end
          chk("busy_in_done", 32'(busy), 32'd0);
        end else begin
          if (q.size() > 0 && cyc > q[0].due) begin
            fail_now("done_timeout");
            void'(q.pop_front());
          end
          exp_busy = (q.size() > 0) && (cyc < q[0].due);
          chk("busy", 32'(busy), 32'(exp_busy));
          chk("hold_result", 32'(result), 32'(h_res));
          chk("hold_carry", 32'(carry), 32'(h_c));
          chk("hold_zero", 32'(zero), 32'(h_z));
`ifdef SERIAL_ALU_OVF_EN
          chk("hold_ovf", 32'(ovf_s), 32'(h_v));
`endif
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf_s), 32'd0);
  endtask

  // Stimulus
  initial begin
    int n;
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    send(8'hFF, 8'h01, 2'b11, 1'b0);  // ADD wraps to zero with carry
    send(8'hF0, 8'h3C, 2'b00, 1'b0);  // AND
    send(8'hAA, 8'hAA, 2'b10, 1'b0);  // XOR to zero
    send(8'h7F, 8'h01, 2'b11, 1'b0);  // ADD signed overflow

    // OR, then an ADD start during RUN that must be ignored
    send(8'h0F, 8'h30, 2'b01, 1'b0);
    @(negedge clk);
    a = 8'hFF; op = 2'b11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Start held across DONE: back-to-back acceptance
    send(8'h80, 8'h80, 2'b11, 1'b1);
    send(8'h5A, 8'hC3, 2'b10, 1'b0);

    // Reset in the middle of RUN, at bit 4
    send(8'h12, 8'h34, 2'b11, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    h_res = 8'h00; h_c = 1'b0; h_z = 1'b1; h_v = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h12, 8'h34, 2'b11, 1'b0);

    // Randomized operations, some back-to-back
    for (int i = 0; i < 150; i++)
      send(8'($urandom), 8'($urandom), 2'($urandom),
           (i != 149) && ($urandom_range(0, 3) == 0));

    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
